// File: rtl/vfu_pkg.sv
// Shared FP16 compare helpers and op encodings for the VFU / softmax blocks.
// Ordering key makes FP16 patterns compare as unsigned integers (-0 < +0, NaNs by bits).
package vfu_pkg;
  localparam int FP16_W = 16;

  typedef enum logic [1:0] {
    OP_MAX    = 2'b00,
    OP_MIN    = 2'b01,
    OP_ROWMAX = 2'b10,
    OP_BYPASS = 2'b11
  } vfu_op_e;

  function automatic logic [FP16_W-1:0] fp16_key(input logic [FP16_W-1:0] x);
    return x[FP16_W-1] ? ~x : (x ^ 16'h8000);
  endfunction

  // Ties return a.
  function automatic logic [FP16_W-1:0] fp16_max(input logic [FP16_W-1:0] a,
                                                 input logic [FP16_W-1:0] b);
    return (fp16_key(a) >= fp16_key(b)) ? a : b;
  endfunction

  function automatic logic [FP16_W-1:0] fp16_min(input logic [FP16_W-1:0] a,
                                                 input logic [FP16_W-1:0] b);
    return (fp16_key(a) <= fp16_key(b)) ? a : b;
  endfunction
endpackage

// File: rtl/vfu_maxred_if.sv
// Stream bus of vfu_maxred: input beat side and output beat side.
interface vfu_maxred_if #(parameter int N = 4, parameter int CNT_W = 8);
  logic               in_tvalid;
  logic               in_tready;
  logic               in_tlast;
  logic [1:0]         INST;
  logic [N*16-1:0]    vect_A;
  logic [N*16-1:0]    vect_B;
  logic               out_tvalid;
  logic               out_tready;
  logic               out_tlast;
  logic [N*16-1:0]    vect_out_flat;
  logic [CNT_W-1:0]   row_cnt;

  modport slave (
    input  in_tvalid, in_tlast, INST, vect_A, vect_B, out_tready,
    output in_tready, out_tvalid, out_tlast, vect_out_flat, row_cnt
  );

  modport master (
    output in_tvalid, in_tlast, INST, vect_A, vect_B, out_tready,
    input  in_tready, out_tvalid, out_tlast, vect_out_flat, row_cnt
  );
endinterface

// File: rtl/fp16_max_tree.sv
// Combinational log2(N)-level max reduction of N FP16 lanes to one word.
module fp16_max_tree import vfu_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N*FP16_W-1:0] vec,
  output logic [FP16_W-1:0]   max_o
);
  localparam int LVL = $clog2(N);
  localparam int P   = 1 << LVL;

  logic [P-1:0][FP16_W-1:0] lvl;

  // Pad lanes hold FFFF (lowest key), so they never win over a real lane.
  always_comb begin
    lvl = '1;
    for (int i = 0; i < N; i++) lvl[i] = vec[i*FP16_W +: FP16_W];
    for (int s = 0; s < LVL; s++)
      for (int i = 0; i < (P >> (s + 1)); i++)
        lvl[i] = fp16_max(lvl[2*i], lvl[2*i+1]);
  end

  assign max_o = lvl[0];
endmodule

// File: rtl/vfu_maxred.sv
// N-lane FP16 max/min/bypass unit with multi-beat row-max reduction, 2-stage valid/ready pipe.
module vfu_maxred import vfu_pkg::*; #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  vfu_maxred_if.slave  bus
);
  localparam int STAGES = 2;

  typedef logic [N-1:0][FP16_W-1:0] vec_t;
  typedef struct packed {
    vfu_op_e           op;
    logic              last;
    logic [FP16_W-1:0] m;
    vec_t              res;
  } s1_t;

  logic [STAGES:1]   vld_pipe;
  s1_t               s1_in, s1;
  vec_t              a_l, b_l, lane_res, out_q;
  logic [FP16_W-1:0] tree_m, acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, row_cnt_q;
  logic              first, last_q, out_fire, s1_adv, row_hit, s2_emit;
  vfu_op_e           in_op;

  assign a_l   = bus.vect_A;
  assign b_l   = bus.vect_B;
  assign in_op = vfu_op_e'(bus.INST);

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane_res[g] = (in_op == OP_MAX) ? fp16_max(a_l[g], b_l[g]) :
                         (in_op == OP_MIN) ? fp16_min(a_l[g], b_l[g]) : a_l[g];
  end

  fp16_max_tree #(.N(N)) u_tree (.vec(bus.vect_A), .max_o(tree_m));

  assign s1_in = '{op: in_op, last: bus.in_tlast, m: tree_m, res: lane_res};

  assign out_fire      = vld_pipe[2] & bus.out_tready;
  assign s1_adv        = vld_pipe[1] & (~vld_pipe[2] | out_fire);
  assign bus.in_tready = ~vld_pipe[1] | s1_adv;

  assign row_hit = (s1.op == OP_ROWMAX);
  assign acc_nxt = first ? s1.m : fp16_max(acc, s1.m);
  assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
  // Non-tlast ROWMAX beats are absorbed into the accumulator and produce nothing.
  assign s2_emit = ~row_hit | s1.last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      s1        <= '0;
      out_q     <= '0;
      last_q    <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      if (bus.in_tready) begin
        vld_pipe[1] <= bus.in_tvalid;
        if (bus.in_tvalid) s1 <= s1_in;
      end
      if (s1_adv) begin
        vld_pipe[2] <= s2_emit;
        if (s2_emit) begin
          out_q     <= row_hit ? {N{acc_nxt}} : s1.res;
          last_q    <= s1.last;
          row_cnt_q <= row_hit ? cnt_nxt : '0;
        end
      end else if (out_fire) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  // Updates only on s1 -> s2 advance so a stalled beat is counted once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b1;
    end else if (s1_adv && row_hit) begin
      if (s1.last) begin
        acc   <= '0;
        cnt   <= '0;
        first <= 1'b1;
      end else begin
        acc   <= acc_nxt;
        cnt   <= cnt_nxt;
        first <= 1'b0;
      end
    end
  end

  assign bus.out_tvalid    = vld_pipe[2];
  assign bus.out_tlast     = last_q;
  assign bus.vect_out_flat = out_q;
  assign bus.row_cnt       = row_cnt_q;
endmodule
